if_fetch_stage: RTL and testbench

- Fetch-stage front end for the 5-stage RISC pipeline.
- Owns the program counter and drives the word address into the instruction memory.
- Captures the returned instruction plus next-PC into the IF/ID pipeline register for decode.
- Handles stall (hold), redirect (branch/jump target) and flush (squash to NOP).

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/if_pc_reg.sv | 30 +++
 rtl/if_fetch_stage.sv | 88 ++++++++
 tb/tb_if_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID record consumed by decode.
// No logic; the bubble() helper builds a squashed IF/ID entry.
// Not applicable: this file holds types and constants only.
package pipeline_pkg;

   localparam int                ADDR_W     = 32;
   localparam int                IMEM_DEPTH = 128;
   localparam logic [31:0]       NOP_INSTR  = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] RESET_PC   = '0;

   typedef struct packed {
      logic [31:0]       instr;
      logic [ADDR_W-1:0] npc;
      logic              valid;
   } if_id_t;

   function automatic if_id_t bubble(input logic [ADDR_W-1:0] npc);
      if_id_t b;
      b.instr = NOP_INSTR;
      b.npc   = npc;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with next-PC select: redirect beats stall beats increment.
// Latency: pc updates one rising edge after the controls are sampled.
// Backpressure: stall holds pc; pc_src redirects even while stalled.
module if_pc_reg #(
   parameter int                ADDR_W   = pipeline_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = pipeline_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              pc_src,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_inc
);

   // Word-indexed PC; the increment wraps naturally at 2^ADDR_W.
   assign pc_inc = pc + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (pc_src) begin
         pc <= branch_target;
      end else if (!stall) begin
         pc <= pc_inc;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: drives PC to imem and registers instr/next-PC into IF/ID. Optional IF_PERF_CNT_EN adds fetch/bubble counters.
// Latency: imem_addr is combinational from PC; the fetched word reaches IF/ID one edge later.
// Backpressure: stall holds PC and IF/ID; flush/pc_src squash IF/ID to a bubble.
module if_fetch_stage #(
   parameter int                ADDR_W     = pipeline_pkg::ADDR_W,
   parameter int                IMEM_DEPTH = pipeline_pkg::IMEM_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC   = pipeline_pkg::RESET_PC,
   parameter logic [31:0]       NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              pc_src,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_npc,
   output logic              if_id_valid,
   output logic              pc_oob
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   import pipeline_pkg::*;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   if_id_t            if_id_q;
   logic              squash;
   logic              load_vld;

   if_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .pc            (pc),
      .pc_inc        (pc_inc)
   );

   assign imem_addr = pc;
   assign pc_oob    = (pc >= ADDR_W'(IMEM_DEPTH));
   assign squash    = flush | pc_src;
   assign load_vld  = !squash && !stall && !pc_oob;

   // Out-of-range fetches become bubbles so undefined memory data never reaches decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_q <= '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
      end else if (squash) begin
         if_id_q <= '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
      end else if (!stall) begin
         if (pc_oob) begin
            if_id_q <= '{instr: NOP_INSTR, npc: pc_inc, valid: 1'b0};
         end else begin
            if_id_q <= '{instr: imem_data, npc: pc_inc, valid: 1'b1};
         end
      end
   end

   assign if_id_instr = if_id_q.instr;
   assign if_id_npc   = if_id_q.npc;
   assign if_id_valid = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
   // Every running edge is either a valid fetch or a bubble/hold, never both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (load_vld) begin
         fetch_cnt  <= fetch_cnt + 32'd1;
      end else begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage against a cycle-level reference model.
// Compile with +define+IF_PERF_CNT_EN to also check the performance counters.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic        if_id_valid;
   logic        pc_oob;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   logic [31:0] mem [128];
   int          errors = 0;
   int          checks = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_npc;
   logic        m_valid;
   logic [31:0] m_fcnt, m_bcnt;

   always #5 clk = ~clk;

   assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

   if_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .if_id_instr   (if_id_instr),
      .if_id_npc     (if_id_npc),
      .if_id_valid   (if_id_valid),
      .pc_oob        (pc_oob)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt),
      .bubble_cnt    (bubble_cnt)
`endif
   );

   task automatic model_reset();
      m_pc = 32'd0; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
      m_fcnt = 32'd0; m_bcnt = 32'd0;
   endtask

   // Advance one clock; the model applies the stated priorities to the inputs seen at the edge.
   task automatic cycle();
      logic [31:0] n_pc, n_instr, n_npc;
      logic        n_valid;
      logic [31:0] p1;
      p1 = m_pc + 32'd1;
      n_pc = pc_src ? branch_target : (stall ? m_pc : p1);
      n_instr = m_instr; n_npc = m_npc; n_valid = m_valid;
      if (flush || pc_src) begin
         n_instr = 32'd0; n_npc = 32'd0; n_valid = 1'b0;
      end else if (!stall) begin
         if (m_pc > 32'd127) begin
            n_instr = 32'd0; n_npc = p1; n_valid = 1'b0;
         end else begin
            n_instr = mem[m_pc[6:0]]; n_npc = p1; n_valid = 1'b1;
         end
      end
      if (n_valid && !(stall && !(flush || pc_src))) m_fcnt = m_fcnt + 32'd1;
      else m_bcnt = m_bcnt + 32'd1;
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_npc = n_npc; m_valid = n_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      mem[0] = 32'h8C01_0000;
      mem[1] = 32'h8C02_0001;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      checks++; if (if_id_instr !== 32'd0 || if_id_npc !== 32'd0 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL reset_ifid got=%h/%h/%b exp=0/0/0", if_id_instr, if_id_npc, if_id_valid); end
      rst_n = 1'b1;
      cycle();
      checks++; if (imem_addr !== 32'd1) begin errors++; $display("FAIL run_addr1 got=%h exp=1", imem_addr); end
      checks++; if (if_id_instr !== 32'h8C01_0000 || if_id_npc !== 32'd1 || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL run_ifid0 got=%h/%h/%b exp=8c010000/1/1", if_id_instr, if_id_npc, if_id_valid); end
      cycle();
      checks++; if (imem_addr !== 32'd2 || if_id_instr !== 32'h8C02_0001 || if_id_npc !== 32'd2) begin
         errors++; $display("FAIL run_ifid1 got=%h/%h/%h exp=2/8c020001/2", imem_addr, if_id_instr, if_id_npc); end
   endtask

   task automatic test_stall();
      repeat (3) cycle();
      checks++; if (imem_addr !== 32'd5) begin errors++; $display("FAIL stall_pre_addr got=%h exp=5", imem_addr); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (imem_addr !== 32'd5 || if_id_instr !== mem[4] || if_id_npc !== 32'd5 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d got=%h/%h/%h/%b exp=5/%h/5/1", i, imem_addr, if_id_instr, if_id_npc, if_id_valid, mem[4]); end
      end
      stall = 1'b0;
      cycle();
      checks++; if (imem_addr !== 32'd6 || if_id_instr !== mem[5] || if_id_npc !== 32'd6) begin
         errors++; $display("FAIL stall_resume got=%h/%h/%h exp=6/%h/6", imem_addr, if_id_instr, if_id_npc, mem[5]); end
   endtask

   task automatic test_redirect();
      cycle();
      pc_src = 1'b1; branch_target = 32'd20;
      cycle();
      pc_src = 1'b0;
      checks++; if (imem_addr !== 32'd20 || if_id_instr !== 32'd0 || if_id_npc !== 32'd0 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL redirect_squash got=%h/%h/%h/%b exp=14/0/0/0", imem_addr, if_id_instr, if_id_npc, if_id_valid); end
      cycle();
      checks++; if (if_id_instr !== mem[20] || if_id_npc !== 32'd21 || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL redirect_fetch got=%h/%h/%b exp=%h/15/1", if_id_instr, if_id_npc, if_id_valid, mem[20]); end
   endtask

   task automatic test_combo();
      pc_src = 1'b1; branch_target = 32'd9;
      cycle();
      stall = 1'b1; branch_target = 32'd3;
      cycle();
      pc_src = 1'b0; flush = 1'b1;
      checks++; if (imem_addr !== 32'd3 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0) begin
         errors++; $display("FAIL src_stall got=%h/%b/%h exp=3/0/0", imem_addr, if_id_valid, if_id_instr); end
      cycle();
      flush = 1'b0; stall = 1'b0;
      checks++; if (imem_addr !== 32'd3 || if_id_valid !== 1'b0 || if_id_npc !== 32'd0) begin
         errors++; $display("FAIL flush_stall got=%h/%b/%h exp=3/0/0", imem_addr, if_id_valid, if_id_npc); end
      cycle();
      checks++; if (imem_addr !== 32'd4 || if_id_instr !== mem[3] || if_id_npc !== 32'd4) begin
         errors++; $display("FAIL combo_resume got=%h/%h/%h exp=4/%h/4", imem_addr, if_id_instr, if_id_npc, mem[3]); end
   endtask

   task automatic test_bounds();
      pc_src = 1'b1; branch_target = 32'd126;
      cycle();
      pc_src = 1'b0;
      checks++; if (imem_addr !== 32'd126 || pc_oob !== 1'b0) begin errors++; $display("FAIL oob_126 got=%h/%b exp=7e/0", imem_addr, pc_oob); end
      cycle();
      checks++; if (imem_addr !== 32'd127 || pc_oob !== 1'b0) begin errors++; $display("FAIL oob_127 got=%h/%b exp=7f/0", imem_addr, pc_oob); end
      cycle();
      checks++; if (imem_addr !== 32'd128 || pc_oob !== 1'b1 || if_id_instr !== mem[127] || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL oob_128 got=%h/%b/%h/%b exp=80/1/%h/1", imem_addr, pc_oob, if_id_instr, if_id_valid, mem[127]); end
      cycle();
      checks++; if (if_id_instr !== 32'd0 || if_id_valid !== 1'b0 || if_id_npc !== 32'd129) begin
         errors++; $display("FAIL oob_bubble got=%h/%b/%h exp=0/0/81", if_id_instr, if_id_valid, if_id_npc); end
      pc_src = 1'b1; branch_target = 32'hFFFF_FFFF;
      cycle();
      pc_src = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFF || pc_oob !== 1'b1) begin errors++; $display("FAIL wrap_pre got=%h/%b exp=ffffffff/1", imem_addr, pc_oob); end
      cycle();
      checks++; if (imem_addr !== 32'd0 || pc_oob !== 1'b0 || if_id_npc !== 32'd0 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL wrap got=%h/%b/%h/%b exp=0/0/0/0", imem_addr, pc_oob, if_id_npc, if_id_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stall  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 7) == 0);
         pc_src = ($urandom_range(0, 7) == 0);
         branch_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 135));
         cycle();
         checks++; if (imem_addr !== m_pc || pc_oob !== (m_pc > 32'd127)) begin
            errors++; $display("FAIL rnd_pc[%0d] got=%h/%b exp=%h", i, imem_addr, pc_oob, m_pc); end
         checks++; if (if_id_instr !== m_instr || if_id_npc !== m_npc || if_id_valid !== m_valid) begin
            errors++; $display("FAIL rnd_ifid[%0d] got=%h/%h/%b exp=%h/%h/%b", i, if_id_instr, if_id_npc, if_id_valid, m_instr, m_npc, m_valid); end
`ifdef IF_PERF_CNT_EN
         checks++; if (fetch_cnt !== m_fcnt || bubble_cnt !== m_bcnt) begin
            errors++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, fetch_cnt, bubble_cnt, m_fcnt, m_bcnt); end
`endif
      end
      stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
   endtask

   task automatic test_async_reset();
      pc_src = 1'b1; branch_target = 32'd38;
      cycle();
      pc_src = 1'b0;
      repeat (2) cycle();
      checks++; if (imem_addr !== 32'd40 || if_id_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got=%h/%b exp=28/1", imem_addr, if_id_valid); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (imem_addr !== 32'd0 || if_id_instr !== 32'd0 || if_id_npc !== 32'd0 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL ar_now got=%h/%h/%h/%b exp=0/0/0/0", imem_addr, if_id_instr, if_id_npc, if_id_valid); end
`ifdef IF_PERF_CNT_EN
      checks++; if (fetch_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
         errors++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", fetch_cnt, bubble_cnt); end
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();
      checks++; if (imem_addr !== 32'd1 || if_id_instr !== mem[0] || if_id_npc !== 32'd1 || if_id_valid !== 1'b1) begin
         errors++; $display("FAIL ar_restart got=%h/%h/%h/%b exp=1/%h/1/1", imem_addr, if_id_instr, if_id_npc, if_id_valid, mem[0]); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = $urandom();
      model_reset();
      test_reset();
      test_stall();
      test_redirect();
      test_combo();
      test_bounds();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
